// File: rtl/fifo_pkg.sv
// Shared definitions for the single-clock FIFO family: flag bundle, default sizes
// and the occupancy counter width.
package fifo_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 16;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

  // The count must represent 0..depth inclusive, hence one bit more than the pointer.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH register array, one synchronous write port, one asynchronous read port.
module fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [DEPTH-1:0][WIDTH-1:0] mem;

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  // Async read sees the pre-edge contents, so a same-address write returns old data.
  assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, almost thresholds and
// selectable standard / first-word-fall-through read mode.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    cnt_q, cnt_nxt;
  logic [WIDTH-1:0] mem_rd;
  logic             wr_acc, rd_acc;
  fifo_status_t     st;

  assign rd_acc  = rd_en & ~st.empty;
  assign wr_acc  = wr_en & (~st.full | rd_acc);
  assign cnt_nxt = cnt_q + CW'(wr_acc) - CW'(rd_acc);

  fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (wdata),
    .raddr (rd_ptr),
    .rdata (mem_rd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
      st     <= '{full: 1'b0, empty: 1'b1, almost_full: 1'b0, almost_empty: 1'b1,
                  overflow: 1'b0, underflow: 1'b0};
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      cnt_q           <= cnt_nxt;
      st.full         <= (cnt_nxt == CW'(DEPTH));
      st.empty        <= (cnt_nxt == '0);
      st.almost_full  <= (cnt_nxt >= CW'(AF_THRESH));
      st.almost_empty <= (cnt_nxt <= CW'(AE_THRESH));
      st.overflow     <= wr_en & ~wr_acc;
      st.underflow    <= rd_en & ~rd_acc;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is presented directly; zero while nothing is stored.
      assign rdata = st.empty ? '0 : mem_rd;
    end else begin : g_std
      logic [WIDTH-1:0] rdata_q;
      always_ff @(posedge clk) begin
        if (rst)         rdata_q <= '0;
        else if (rd_acc) rdata_q <= mem_rd;
      end
      assign rdata = rdata_q;
    end
  endgenerate

  assign count        = cnt_q;
  assign full         = st.full;
  assign empty        = st.empty;
  assign almost_full  = st.almost_full;
  assign almost_empty = st.almost_empty;
  assign overflow     = st.overflow;
  assign underflow    = st.underflow;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench: a standard-mode and an FWFT-mode FIFO compared against a queue model.
module tb_sync_fifo_param;
  localparam int W  = 8;
  localparam int D  = 16;
  localparam int AF = D - 2;
  localparam int AE = 2;
  localparam int CW = $clog2(D) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wr0 = 1'b0, rd0 = 1'b0, wr1 = 1'b0, rd1 = 1'b0;
  logic [W-1:0] wd0 = '0, wd1 = '0;
  logic [W-1:0] rdata0, rdata1;
  logic full0, empty0, af0, ae0, ovf0, unf0;
  logic full1, empty1, af1, ae1, ovf1, unf1;
  logic [CW-1:0] count0, count1;

  int checks = 0;
  int failures = 0;

  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  logic [W-1:0] exp_rd0 = '0;
  bit exp_ovf = 0, exp_unf = 0;

  always #5 clk = ~clk;

  sync_fifo_param #(.WIDTH(W), .DEPTH(D), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .wr_en(wr0), .wdata(wd0), .rd_en(rd0), .rdata(rdata0),
    .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0),
    .count(count0), .overflow(ovf0), .underflow(unf0));

  sync_fifo_param #(.WIDTH(W), .DEPTH(D), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .wr_en(wr1), .wdata(wd1), .rd_en(rd1), .rdata(rdata1),
    .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1),
    .count(count1), .overflow(ovf1), .underflow(unf1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
  endtask

  // Compare one DUT against the model state (queue size, pulses, head/last read word).
  task automatic check_state(input bit f);
    int sz;
    sz = f ? q1.size() : q0.size();
    chk(f ? "f.count" : "s.count", f ? 32'(count1) : 32'(count0), 32'(sz));
    chk(f ? "f.full"  : "s.full",  f ? 32'(full1)  : 32'(full0),  32'(sz == D));
    chk(f ? "f.empty" : "s.empty", f ? 32'(empty1) : 32'(empty0), 32'(sz == 0));
    chk(f ? "f.af"    : "s.af",    f ? 32'(af1)    : 32'(af0),    32'(sz >= AF));
    chk(f ? "f.ae"    : "s.ae",    f ? 32'(ae1)    : 32'(ae0),    32'(sz <= AE));
    chk(f ? "f.ovf"   : "s.ovf",   f ? 32'(ovf1)   : 32'(ovf0),   32'(exp_ovf));
    chk(f ? "f.unf"   : "s.unf",   f ? 32'(unf1)   : 32'(unf0),   32'(exp_unf));
    if (!f) chk("s.rdata", 32'(rdata0), 32'(exp_rd0));
    else if (sz > 0) chk("f.rdata", 32'(rdata1), 32'(q1[0]));
  endtask

  // One clock with the chosen DUT driven; the other idles.
  task automatic step(input bit f, input bit wr, input logic [W-1:0] d, input bit rd);
    int sz;
    bit rd_ok, wr_ok;
    wr0 = f ? 1'b0 : wr; rd0 = f ? 1'b0 : rd; wd0 = d;
    wr1 = f ? wr : 1'b0; rd1 = f ? rd : 1'b0; wd1 = d;
    @(posedge clk); #1;
    wr0 = 0; rd0 = 0; wr1 = 0; rd1 = 0;
    sz = f ? q1.size() : q0.size();
    rd_ok = rd && sz > 0;
    wr_ok = wr && (sz < D || rd_ok);
    if (rd_ok) begin
      if (f) void'(q1.pop_front());
      else   exp_rd0 = q0.pop_front();
    end
    if (wr_ok) begin
      if (f) q1.push_back(d);
      else   q0.push_back(d);
    end
    exp_ovf = wr && !wr_ok;
    exp_unf = rd && !rd_ok;
    check_state(f);
  endtask

  task automatic do_reset(input int n);
    rst = 1; wr0 = 0; rd0 = 0; wr1 = 0; rd1 = 0;
    repeat (n) @(posedge clk);
    #1 rst = 0;
    q0.delete(); q1.delete();
    exp_rd0 = '0; exp_ovf = 0; exp_unf = 0;
    check_state(0);
    check_state(1);
  endtask

  initial begin
    // Reset
    do_reset(2);

    // Fill 0x01..0x10, one rejected write, then drain in order
    for (int i = 1; i <= D; i++) step(0, 1, W'(i), 0);
    step(0, 1, 8'hEE, 0);
    step(0, 0, 8'h00, 0);
    for (int i = 1; i <= D; i++) step(0, 0, 8'h00, 1);

    // Underflow on empty: rdata holds 0x10
    step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 0);

    // Simultaneous read/write at full, then at empty
    for (int i = 0; i < D; i++) step(0, 1, W'($urandom), 0);
    step(0, 1, 8'h77, 1);
    for (int i = 0; i < D; i++) step(0, 0, 8'h00, 1);
    step(0, 1, 8'h5A, 1);
    step(0, 0, 8'h00, 1);

    // Random interleave with repeated pointer wrap
    for (int i = 0; i < 120; i++)
      step(0, 1'($urandom_range(1, 0)), W'($urandom), 1'($urandom_range(1, 0)));

    // FWFT: word visible without rd_en, pop empties
    step(1, 1, 8'hA5, 0);
    step(1, 0, 8'h00, 0);
    step(1, 0, 8'h00, 1);

    // FWFT: reset with 9 entries stored discards them
    for (int i = 0; i < 9; i++) step(1, 1, W'(8'h90 + i), 0);
    do_reset(1);
    step(1, 1, 8'h3C, 0);
    step(1, 0, 8'h00, 1);
    step(1, 0, 8'h00, 1);

    // FWFT random traffic, including full/empty corners
    for (int i = 0; i < 20; i++) step(1, 1, W'($urandom), 0);
    for (int i = 0; i < 100; i++)
      step(1, 1'($urandom_range(1, 0)), W'($urandom), 1'($urandom_range(1, 0)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
